// File: rtl/serving_mem_arbiter.sv
// ============================================================================
// serving_mem_arbiter
//
// Purpose:
//   Shares the single Wishbone RAM port of the serving SoC between the SERV
//   core (internal requester) and the AXI2WB bridge master (external
//   requester). Arbitration is round-robin, and each grant covers exactly one
//   Wishbone transaction. The five memory mux select lines read 1 while the
//   external requester owns the RAM and 0 otherwise.
//
// Optional feature (compile-time macro ARB_TIMEOUT_EN):
//   When defined, a grant that sees no i_mem_ack for TIMEOUT grant cycles is
//   force-terminated. The granted requester gets ack = 1 and rdt = 0, and
//   o_err pulses for that one cycle. When undefined, no counter is built,
//   o_err is tied to 0 and a grant waits indefinitely for the RAM.
//
// Parameters:
//   AW      byte address width; word address buses are [AW-1:2]
//   TIMEOUT grant cycles allowed without ack (ARB_TIMEOUT_EN only)
//
// Ports:
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_cpu_*                   core Wishbone request (stb held until ack)
//   o_cpu_rdt, o_cpu_ack      core response
//   i_ext_*                   bridge Wishbone request (same semantics)
//   o_ext_rdt, o_ext_ack      bridge response
//   o_mem_*                   RAM Wishbone port (muxed from the grant)
//   i_mem_rdt, i_mem_ack      RAM response
//   o_sel_radr/wadr/wdata/rdata/wen  mux selects, 1 = external owns RAM
//   o_err                     timeout pulse
// ============================================================================
module serving_mem_arbiter #(
    parameter int AW      = 12,
    parameter int TIMEOUT = 255
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    // core port
    input  logic [AW-1:2] i_cpu_adr,
    input  logic [31:0]   i_cpu_dat,
    input  logic [3:0]    i_cpu_sel,
    input  logic          i_cpu_we,
    input  logic          i_cpu_stb,
    output logic [31:0]   o_cpu_rdt,
    output logic          o_cpu_ack,
    // bridge port
    input  logic [AW-1:2] i_ext_adr,
    input  logic [31:0]   i_ext_dat,
    input  logic [3:0]    i_ext_sel,
    input  logic          i_ext_we,
    input  logic          i_ext_stb,
    output logic [31:0]   o_ext_rdt,
    output logic          o_ext_ack,
    // RAM port
    output logic [AW-1:2] o_mem_adr,
    output logic [31:0]   o_mem_dat,
    output logic [3:0]    o_mem_sel,
    output logic          o_mem_we,
    output logic          o_mem_stb,
    input  logic [31:0]   i_mem_rdt,
    input  logic          i_mem_ack,
    // mux selects
    output logic          o_sel_radr,
    output logic          o_sel_wadr,
    output logic          o_sel_wdata,
    output logic          o_sel_rdata,
    output logic          o_sel_wen,
    output logic          o_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_CPU = 2'd1,
        GNT_EXT = 2'd2
    } state_t;

    state_t r_state;
    logic   r_last_ext;

    logic   w_gnt_cpu;
    logic   w_gnt_ext;
    logic   w_gnt_stb;
    logic   w_timeout;
    logic   w_done;

    assign w_gnt_cpu = (r_state == GNT_CPU);
    assign w_gnt_ext = (r_state == GNT_EXT);
    // stb of whichever requester currently owns the RAM (0 in IDLE)
    assign w_gnt_stb = (w_gnt_cpu & i_cpu_stb) | (w_gnt_ext & i_ext_stb);

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_cnt;

    // The counter holds the number of completed ack-less grant cycles, so it
    // equals TIMEOUT-1 during the TIMEOUT-th grant cycle, which is the cycle
    // that is force-terminated.
    assign w_timeout = w_gnt_stb & ~i_mem_ack & (r_cnt == CW'(TIMEOUT - 1));
    logic w_unused;
    assign w_unused = 1'b0;
`else
    assign w_timeout = 1'b0;
    logic w_unused;
    assign w_unused = (TIMEOUT == 0);
`endif

    // A transaction ends on a RAM ack or a forced timeout
    assign w_done = (w_gnt_cpu | w_gnt_ext) & (i_mem_ack | w_timeout);

    // Grant FSM: round-robin pick in IDLE, one transaction per grant
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_last_ext <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            r_cnt      <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
`ifdef ARB_TIMEOUT_EN
                    r_cnt <= '0;
`endif
                    if (i_cpu_stb && i_ext_stb) begin
                        // tie goes to whoever was not served last
                        r_state <= r_last_ext ? GNT_CPU : GNT_EXT;
                    end else if (i_cpu_stb) begin
                        r_state <= GNT_CPU;
                    end else if (i_ext_stb) begin
                        r_state <= GNT_EXT;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                GNT_CPU, GNT_EXT: begin
                    if (w_done) begin
                        r_state    <= IDLE;
                        r_last_ext <= w_gnt_ext;
                    end else if (!w_gnt_stb) begin
                        // requester abandoned the cycle: release without ack
                        r_state <= IDLE;
                    end else begin
                        r_state <= r_state;
`ifdef ARB_TIMEOUT_EN
                        r_cnt   <= r_cnt + CW'(1);
`endif
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // RAM request mux: follows the registered grant, all zero in IDLE
    always_comb begin
        o_mem_adr = '0;
        o_mem_dat = 32'h0000_0000;
        o_mem_sel = 4'h0;
        o_mem_we  = 1'b0;
        o_mem_stb = 1'b0;
        if (w_gnt_ext) begin
            o_mem_adr = i_ext_adr;
            o_mem_dat = i_ext_dat;
            o_mem_sel = i_ext_sel;
            o_mem_we  = i_ext_we;
            o_mem_stb = i_ext_stb;
        end else if (w_gnt_cpu) begin
            o_mem_adr = i_cpu_adr;
            o_mem_dat = i_cpu_dat;
            o_mem_sel = i_cpu_sel;
            o_mem_we  = i_cpu_we;
            o_mem_stb = i_cpu_stb;
        end else begin
            o_mem_stb = 1'b0;
        end
    end

    // Response routing: only the granted requester sees ack/rdt; a timeout
    // acks with zero data. Acks arriving in IDLE reach nobody.
    always_comb begin
        o_cpu_ack = 1'b0;
        o_cpu_rdt = 32'h0000_0000;
        o_ext_ack = 1'b0;
        o_ext_rdt = 32'h0000_0000;
        if (w_gnt_cpu) begin
            o_cpu_ack = i_mem_ack | w_timeout;
            o_cpu_rdt = i_mem_ack ? i_mem_rdt : 32'h0000_0000;
        end else if (w_gnt_ext) begin
            o_ext_ack = i_mem_ack | w_timeout;
            o_ext_rdt = i_mem_ack ? i_mem_rdt : 32'h0000_0000;
        end else begin
            o_cpu_ack = 1'b0;
            o_ext_ack = 1'b0;
        end
    end

    assign o_sel_radr  = w_gnt_ext;
    assign o_sel_wadr  = w_gnt_ext;
    assign o_sel_wdata = w_gnt_ext;
    assign o_sel_rdata = w_gnt_ext;
    assign o_sel_wen   = w_gnt_ext;
    assign o_err       = w_timeout;

endmodule

// File: tb/tb_serving_mem_arbiter.sv
// ============================================================================
// tb_serving_mem_arbiter
//
// Directed self-checking bench for serving_mem_arbiter. A small single-cycle
// RAM model answers o_mem_stb one cycle later. Expected responses
// ({is_ext, rdt}) are queued when a request is issued and popped when an ack
// appears.
// ============================================================================
module tb_serving_mem_arbiter;

    localparam int AW = 12;

    logic          clk;
    logic          rst_n;
    logic [AW-1:2] cpu_adr;
    logic [31:0]   cpu_dat;
    logic [3:0]    cpu_sel;
    logic          cpu_we;
    logic          cpu_stb;
    logic [31:0]   cpu_rdt;
    logic          cpu_ack;
    logic [AW-1:2] ext_adr;
    logic [31:0]   ext_dat;
    logic [3:0]    ext_sel;
    logic          ext_we;
    logic          ext_stb;
    logic [31:0]   ext_rdt;
    logic          ext_ack;
    logic [AW-1:2] mem_adr;
    logic [31:0]   mem_dat;
    logic [3:0]    mem_sel;
    logic          mem_we;
    logic          mem_stb;
    logic [31:0]   mem_rdt;
    logic          mem_ack;
    logic          sel_radr, sel_wadr, sel_wdata, sel_rdata, sel_wen;
    logic          err;

    logic [31:0]   ram [0:1023];
    logic          ram_mute;

    logic [32:0]   sb [$];
    int            n_tests;
    int            n_fail;
    int            cycle_no;

    serving_mem_arbiter #(.AW(AW), .TIMEOUT(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_cpu_adr(cpu_adr), .i_cpu_dat(cpu_dat), .i_cpu_sel(cpu_sel),
        .i_cpu_we(cpu_we), .i_cpu_stb(cpu_stb),
        .o_cpu_rdt(cpu_rdt), .o_cpu_ack(cpu_ack),
        .i_ext_adr(ext_adr), .i_ext_dat(ext_dat), .i_ext_sel(ext_sel),
        .i_ext_we(ext_we), .i_ext_stb(ext_stb),
        .o_ext_rdt(ext_rdt), .o_ext_ack(ext_ack),
        .o_mem_adr(mem_adr), .o_mem_dat(mem_dat), .o_mem_sel(mem_sel),
        .o_mem_we(mem_we), .o_mem_stb(mem_stb),
        .i_mem_rdt(mem_rdt), .i_mem_ack(mem_ack),
        .o_sel_radr(sel_radr), .o_sel_wadr(sel_wadr), .o_sel_wdata(sel_wdata),
        .o_sel_rdata(sel_rdata), .o_sel_wen(sel_wen),
        .o_err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-cycle RAM: ack and read data one cycle after stb is seen
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_ack <= 1'b0;
            mem_rdt <= 32'h0;
        end else begin
            mem_ack <= mem_stb && !mem_ack && !ram_mute;
            mem_rdt <= (mem_stb && !mem_we) ? ram[mem_adr] : 32'h0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cycle_no++;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sels();
        return {27'h0, sel_radr, sel_wadr, sel_wdata, sel_rdata, sel_wen};
    endfunction

    // Pop the oldest expected response and compare it with the current ack
    task automatic sb_check(input string tag);
        logic [32:0] e;
        n_tests++;
        assert (sb.size() > 0) else begin
            n_fail++;
            $error("FAIL %s_sb: observed empty queue expected an entry", tag);
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_side"}, {31'h0, ext_ack}, {31'h0, e[32]});
            chk({tag, "_rdt"}, e[32] ? ext_rdt : cpu_rdt, e[31:0]);
            chk({tag, "_other_rdt"}, e[32] ? cpu_rdt : ext_rdt, 32'h0);
            chk({tag, "_single_ack"}, {31'h0, cpu_ack & ext_ack}, 32'h0);
        end
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        cpu_stb = 1'b0;
        ext_stb = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int last_ack;
        int waited;
        n_tests  = 0;
        n_fail   = 0;
        cycle_no = 0;
        ram_mute = 1'b0;
        rst_n    = 1'b0;
        cpu_adr = '0; cpu_dat = 32'h0; cpu_sel = 4'h0; cpu_we = 1'b0; cpu_stb = 1'b0;
        ext_adr = '0; ext_dat = 32'h0; ext_sel = 4'h0; ext_we = 1'b0; ext_stb = 1'b0;
        for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
        ram[10'h010] = 32'hCAFE_F00D;
        ram[10'h030] = 32'hA0A0_0001;
        ram[10'h031] = 32'hB0B0_0002;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_stb", {31'h0, mem_stb}, 32'h0);
        chk("rst_mem_adr", {22'h0, mem_adr}, 32'h0);
        chk("rst_acks", {30'h0, cpu_ack, ext_ack}, 32'h0);
        chk("rst_sels", sels(), 32'h0);
        chk("rst_err", {31'h0, err}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("idle_mem_stb", {31'h0, mem_stb}, 32'h0);
        chk("idle_rdt", cpu_rdt | ext_rdt, 32'h0);

        // ---- core-only read ----
        sb.push_back({1'b0, 32'hCAFE_F00D});
        cpu_adr = 10'h010; cpu_we = 1'b0; cpu_sel = 4'hF; cpu_stb = 1'b1;
        chk("cpu_n_stb", {31'h0, mem_stb}, 32'h0);
        tick();
        chk("cpu_n1_stb", {31'h0, mem_stb}, 32'h1);
        chk("cpu_n1_adr", {22'h0, mem_adr}, 32'h10);
        chk("cpu_n1_sels", sels(), 32'h0);
        chk("cpu_n1_ack", {31'h0, cpu_ack}, 32'h0);
        tick();
        chk("cpu_n2_ack", {31'h0, cpu_ack}, 32'h1);
        chk("cpu_n2_sels", sels(), 32'h0);
        sb_check("cpu_read");
        cpu_stb = 1'b0;
        tick();
        chk("cpu_n3_stb", {31'h0, mem_stb}, 32'h0);
        chk("cpu_n3_ack", {30'h0, cpu_ack, ext_ack}, 32'h0);

        // ---- bridge-only write ----
        sb.push_back({1'b1, 32'h0});
        ext_adr = 10'h020; ext_dat = 32'h1234_5678; ext_sel = 4'hF; ext_we = 1'b1; ext_stb = 1'b1;
        tick();
        chk("ext_n1_stb", {31'h0, mem_stb}, 32'h1);
        chk("ext_n1_we", {31'h0, mem_we}, 32'h1);
        chk("ext_n1_dat", mem_dat, 32'h1234_5678);
        chk("ext_n1_sel", {28'h0, mem_sel}, 32'hF);
        chk("ext_n1_adr", {22'h0, mem_adr}, 32'h20);
        chk("ext_n1_sels", sels(), 32'h1F);
        chk("ext_n1_ack", {31'h0, ext_ack}, 32'h0);
        tick();
        chk("ext_n2_ack", {31'h0, ext_ack}, 32'h1);
        sb_check("ext_write");
        ext_stb = 1'b0; ext_we = 1'b0;
        tick();
        chk("ext_n3_sels", sels(), 32'h0);

        // ---- core abandons its cycle before ack ----
        cpu_adr = 10'h011; cpu_stb = 1'b1;
        tick();
        chk("drop_gnt_stb", {31'h0, mem_stb}, 32'h1);
        cpu_stb = 1'b0;
        #1;
        chk("drop_stb_falls", {31'h0, mem_stb}, 32'h0);
        tick();
        chk("drop_no_ack", {30'h0, cpu_ack, ext_ack}, 32'h0);
        sb.push_back({1'b1, 32'hB0B0_0002});
        ext_adr = 10'h031; ext_stb = 1'b1;
        tick();
        chk("drop_then_ext_sels", sels(), 32'h1F);
        tick();
        chk("drop_then_ext_ack", {31'h0, ext_ack}, 32'h1);
        sb_check("drop_then_ext");
        ext_stb = 1'b0;
        tick();

        // ---- async reset in GNT_EXT before ack ----
        ext_adr = 10'h020; ext_stb = 1'b1;
        tick();
        chk("rstmid_gnt_sels", sels(), 32'h1F);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstmid_stb", {31'h0, mem_stb}, 32'h0);
        chk("rstmid_sels", sels(), 32'h0);
        chk("rstmid_ack", {31'h0, ext_ack}, 32'h0);
        ext_stb = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        sb.push_back({1'b0, 32'hCAFE_F00D});
        cpu_adr = 10'h010; cpu_stb = 1'b1;
        tick();
        chk("rstmid_cpu_stb", {31'h0, mem_stb}, 32'h1);
        chk("rstmid_cpu_sels", sels(), 32'h0);
        tick();
        chk("rstmid_cpu_ack", {31'h0, cpu_ack}, 32'h1);
        sb_check("rstmid_cpu");
        cpu_stb = 1'b0;
        tick();

        // ---- both requesting continuously after reset ----
        do_reset();
        sb.push_back({1'b1, 32'hB0B0_0002});
        sb.push_back({1'b0, 32'hA0A0_0001});
        sb.push_back({1'b1, 32'hB0B0_0002});
        sb.push_back({1'b0, 32'hA0A0_0001});
        cpu_adr = 10'h030; cpu_we = 1'b0; cpu_stb = 1'b1;
        ext_adr = 10'h031; ext_we = 1'b0; ext_stb = 1'b1;
        last_ack = cycle_no;
        for (int k = 0; k < 4; k++) begin
            waited = 0;
            do begin
                tick();
                waited++;
            end while (!(cpu_ack || ext_ack) && waited < 10);
            n_tests++;
            assert (cpu_ack || ext_ack) else begin
                n_fail++;
                $error("FAIL rr_wait_%0d: observed no ack expected ack within 10 cycles", k);
            end
            chk($sformatf("rr_gap_%0d", k), cycle_no - last_ack, (k == 0) ? 32'd2 : 32'd3);
            last_ack = cycle_no;
            sb_check($sformatf("rr_%0d", k));
        end
        cpu_stb = 1'b0;
        ext_stb = 1'b0;
        tick();
        chk("rr_queue_empty", sb.size(), 32'd0);

`ifdef ARB_TIMEOUT_EN
        // ---- RAM never acks: forced termination on the 8th grant cycle ----
        tick();
        ram_mute = 1'b1;
        sb.push_back({1'b0, 32'h0});
        cpu_adr = 10'h010; cpu_stb = 1'b1;
        for (int i = 1; i < 8; i++) begin
            tick();
            chk($sformatf("to_wait_ack_%0d", i), {31'h0, cpu_ack}, 32'h0);
            chk($sformatf("to_wait_err_%0d", i), {31'h0, err}, 32'h0);
        end
        tick();
        chk("to_ack", {31'h0, cpu_ack}, 32'h1);
        chk("to_err", {31'h0, err}, 32'h1);
        sb_check("to");
        cpu_stb = 1'b0;
        tick();
        chk("to_after_err", {31'h0, err}, 32'h0);
        chk("to_after_stb", {31'h0, mem_stb}, 32'h0);
        ram_mute = 1'b0;
`else
        chk("no_timeout_err", {31'h0, err}, 32'h0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
